// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, combinational memory fetch, and a
// 2-entry {instruction, pc} queue feeding a valid/ready consumer.
module fetch_unit #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC     = '0,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD    = DATA_WIDTH'(32'hFFFF_FFFF)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic                  branch_taken_i,
    input  logic [DATA_WIDTH-1:0] branch_target_i,
    output logic [DATA_WIDTH-1:0] address_o,
    input  logic [DATA_WIDTH-1:0] mem_instruction_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instruction_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic                  halted_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    localparam logic [DATA_WIDTH-1:0] MEM_BYTES = DATA_WIDTH'(MEMORY_DEPTH * 4);

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic [DATA_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] pc_inc;
    logic [DATA_WIDTH-1:0] pc_seq;
    logic [DATA_WIDTH-1:0] branch_pc;
    logic [1:0]            count;
    logic                  pop;
    logic                  push;
    logic                  push_to_head;
    logic [DATA_WIDTH-1:0] tail_instr;
    logic [DATA_WIDTH-1:0] tail_pc;

    assign pc_inc    = pc + DATA_WIDTH'(4);
    assign pc_seq    = (pc_inc == MEM_BYTES) ? '0 : pc_inc;
    assign branch_pc = (branch_target_i & ~DATA_WIDTH'(3)) % MEM_BYTES;

    assign pop  = (count != 2'd0) && instr_ready_i;
    assign push = (state == RUN) && !branch_taken_i && ((count != 2'd2) || pop);

    // The new entry lands in the head slot whenever the queue is empty after this cycle's pop.
    assign push_to_head = (count == 2'd0) || ((count == 2'd1) && pop);

    assign address_o     = pc;
    assign instr_valid_o = (count != 2'd0);
    assign halted_o      = (state == HALT);

    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            IDLE: if (enable_i && !branch_taken_i) state_next = RUN;
            RUN: begin
                if (push && (mem_instruction_i == HALT_WORD)) state_next = HALT;
                else if (!enable_i)                            state_next = IDLE;
            end
            HALT:    if (branch_taken_i) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the two queue slots are plain registers, so they are reset with everything else.
            state         <= IDLE;
            pc            <= RESET_PC;
            count         <= 2'd0;
            instruction_o <= '0;
            pc_o          <= '0;
            tail_instr    <= '0;
            tail_pc       <= '0;
        end else begin
            state <= state_next;
            if (branch_taken_i) begin
                pc    <= branch_pc;
                count <= 2'd0;
            end else begin
                count <= count + 2'(push) - 2'(pop);
                if (pop && (count == 2'd2)) begin
                    instruction_o <= tail_instr;
                    pc_o          <= tail_pc;
                end
                if (push) begin
                    pc <= pc_seq;
                    if (push_to_head) begin
                        instruction_o <= mem_instruction_i;
                        pc_o          <= pc;
                    end else begin
                        tail_instr <= mem_instruction_i;
                        tail_pc    <= pc;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a 32-word memory model answers address_o,
// and expected {instruction, pc} pairs are queued and compared as the consumer pops.
module tb_fetch_unit;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic [31:0] address_o;
    logic [31:0] mem_instruction_i;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic        halted_o;

    logic [31:0] mem [32];
    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_err = 0;

    fetch_unit dut (
        .clk               (clk),
        .reset             (reset),
        .enable_i          (enable_i),
        .branch_taken_i    (branch_taken_i),
        .branch_target_i   (branch_target_i),
        .address_o         (address_o),
        .mem_instruction_i (mem_instruction_i),
        .instr_valid_o     (instr_valid_o),
        .instr_ready_i     (instr_ready_i),
        .instruction_o     (instruction_o),
        .pc_o              (pc_o),
        .halted_o          (halted_o)
    );

    always #5 clk = ~clk;

    assign mem_instruction_i = mem[5'(address_o >> 2)];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_memory();
        for (int k = 0; k < 32; k++) mem[k] = 32'(k);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        branch_taken_i = 1'b0;
        sb.delete();
        step();
        step();
        reset = 1'b0;
    endtask

    // Consumes n entries from the DUT, comparing each against the scoreboard.
    task automatic drain(input int n, input int budget, input string tag, output int cycles);
        int got = 0;
        cycles = 0;
        while (got < n && cycles < budget) begin
            if (instr_valid_o && instr_ready_i) begin
                exp_t e = sb.pop_front();
                n_cmp++;
                if (instruction_o !== e.instr) begin
                    n_err++;
                    $display("FAIL %s instr[%0d]: got %h expected %h", tag, got, instruction_o, e.instr);
                end
                n_cmp++;
                if (pc_o !== e.pc) begin
                    n_err++;
                    $display("FAIL %s pc[%0d]: got %h expected %h", tag, got, pc_o, e.pc);
                end
                got++;
            end
            if (got < n) begin
                step();
                cycles++;
            end
        end
        if (got < n) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: got %0d entries expected %0d", tag, got, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        n_cmp++;
        if ({instr_valid_o, halted_o} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_flags: got valid=%b halted=%b expected 0 0", instr_valid_o, halted_o);
        end
        n_cmp++;
        if (instruction_o !== 32'h0 || pc_o !== 32'h0) begin
            n_err++;
            $display("FAIL reset_head: got instr=%h pc=%h expected 0 0", instruction_o, pc_o);
        end
        n_cmp++;
        if (address_o !== 32'h0) begin
            n_err++;
            $display("FAIL reset_addr: got %h expected 0", address_o);
        end
    endtask

    task automatic test_sequential();
        int cyc;
        load_memory();
        enable_i = 1'b1;
        instr_ready_i = 1'b1;
        apply_reset();
        for (int k = 0; k < 10; k++) sb.push_back('{32'(k), 32'(4 * k)});
        drain(10, 40, "seq", cyc);
        n_cmp++;
        if (cyc !== 11) begin
            n_err++;
            $display("FAIL seq_timing: got %0d cycles expected 11", cyc);
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        load_memory();
        enable_i = 1'b1;
        instr_ready_i = 1'b0;
        apply_reset();
        for (int k = 0; k < 5; k++) step();
        n_cmp++;
        if (address_o !== 32'h8) begin
            n_err++;
            $display("FAIL bp_addr: got %h expected 00000008", address_o);
        end
        n_cmp++;
        if (instr_valid_o !== 1'b1 || instruction_o !== 32'h0 || pc_o !== 32'h0) begin
            n_err++;
            $display("FAIL bp_hold: got valid=%b instr=%h pc=%h expected 1 0 0",
                     instr_valid_o, instruction_o, pc_o);
        end
        for (int k = 0; k < 4; k++) sb.push_back('{32'(k), 32'(4 * k)});
        instr_ready_i = 1'b1;
        drain(4, 20, "bp", cyc);
    endtask

    task automatic test_branch();
        int cyc;
        load_memory();
        enable_i = 1'b1;
        instr_ready_i = 1'b0;
        apply_reset();
        for (int k = 0; k < 5; k++) step();
        branch_taken_i = 1'b1;
        branch_target_i = 32'h43;
        step();
        branch_taken_i = 1'b0;
        n_cmp++;
        if (instr_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL br_flush: got valid=%b expected 0", instr_valid_o);
        end
        n_cmp++;
        if (address_o !== 32'h40) begin
            n_err++;
            $display("FAIL br_addr: got %h expected 00000040", address_o);
        end
        sb.push_back('{32'd16, 32'h40});
        sb.push_back('{32'd17, 32'h44});
        instr_ready_i = 1'b1;
        drain(2, 20, "br", cyc);
    endtask

    task automatic test_wrap_halt();
        int cyc;
        load_memory();
        mem[3] = HALT_WORD;
        enable_i = 1'b1;
        instr_ready_i = 1'b1;
        apply_reset();
        step();
        branch_taken_i = 1'b1;
        branch_target_i = 32'h74;
        step();
        branch_taken_i = 1'b0;
        sb.push_back('{32'd29, 32'h74});
        sb.push_back('{32'd30, 32'h78});
        sb.push_back('{32'd31, 32'h7C});
        sb.push_back('{32'd0, 32'h00});
        sb.push_back('{32'd1, 32'h04});
        sb.push_back('{32'd2, 32'h08});
        sb.push_back('{HALT_WORD, 32'h0C});
        drain(7, 30, "wrap", cyc);
        n_cmp++;
        if (halted_o !== 1'b1) begin
            n_err++;
            $display("FAIL halt_flag: got %b expected 1", halted_o);
        end
        for (int k = 0; k < 3; k++) step();
        n_cmp++;
        if (instr_valid_o !== 1'b0 || address_o !== 32'h10) begin
            n_err++;
            $display("FAIL halt_hold: got valid=%b addr=%h expected 0 00000010", instr_valid_o, address_o);
        end
        branch_taken_i = 1'b1;
        branch_target_i = 32'h20;
        step();
        branch_taken_i = 1'b0;
        sb.push_back('{32'd8, 32'h20});
        sb.push_back('{32'd9, 32'h24});
        drain(2, 20, "resume", cyc);
        n_cmp++;
        if (halted_o !== 1'b0) begin
            n_err++;
            $display("FAIL resume_flag: got halted=%b expected 0", halted_o);
        end
    endtask

    task automatic test_async_reset();
        load_memory();
        enable_i = 1'b1;
        instr_ready_i = 1'b0;
        apply_reset();
        for (int k = 0; k < 5; k++) step();
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (instr_valid_o !== 1'b0 || address_o !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset: got valid=%b addr=%h expected 0 00000000", instr_valid_o, address_o);
        end
        enable_i = 1'b0;
        #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) step();
        n_cmp++;
        if (instr_valid_o !== 1'b0 || address_o !== 32'h0 || halted_o !== 1'b0) begin
            n_err++;
            $display("FAIL idle_hold: got valid=%b addr=%h halted=%b expected 0 00000000 0",
                     instr_valid_o, address_o, halted_o);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        load_memory();
        #1;
        test_reset();
        test_sequential();
        test_backpressure();
        test_branch();
        test_wrap_halt();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
